// File: rtl/op_schedule_ctrl.sv
// Loop-nest schedule generator for one unified-buffer port: walks a 4-level nest
// with programmable start delay and initiation interval, driving valid/last/ctrl_vars.
module op_schedule_ctrl #(
    parameter int unsigned W           = 16,
    parameter int unsigned EXT0        = 1,
    parameter int unsigned EXT1        = 4,
    parameter int unsigned EXT2        = 32,
    parameter int unsigned EXT3        = 32,
    parameter int unsigned START_DELAY = 0,
    parameter int unsigned II          = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         en,
    output logic         valid,
    output logic [W-1:0] ctrl_vars [3:0],
    output logic         last,
    output logic         done
);

    localparam int unsigned DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int unsigned II_W  = (II > 1) ? $clog2(II) : 1;

    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [II_W-1:0]  II_MAX   = II_W'(II - 1);

    localparam logic [W-1:0] LAST0 = W'(EXT0 - 1);
    localparam logic [W-1:0] LAST1 = W'(EXT1 - 1);
    localparam logic [W-1:0] LAST2 = W'(EXT2 - 1);
    localparam logic [W-1:0] LAST3 = W'(EXT3 - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        RUN,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [DLY_W-1:0] dly_cnt, dly_nxt;
    logic [II_W-1:0]  ii_cnt, ii_nxt;
    logic [W-1:0]     vars_nxt [3:0];
    logic [3:0]       at_end;
    logic             carry;

    assign at_end = {ctrl_vars[3] == LAST3, ctrl_vars[2] == LAST2,
                     ctrl_vars[1] == LAST1, ctrl_vars[0] == LAST0};

    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_cnt;
        ii_nxt    = ii_cnt;
        vars_nxt  = ctrl_vars;
        carry     = 1'b1;
        valid     = (state == RUN) && (ii_cnt == '0) && en;
        last      = valid && (&at_end);
        done      = (state == DONE);

        if (flush) begin
            for (int unsigned i = 0; i < 4; i++) vars_nxt[i] = '0;
            ii_nxt  = '0;
            dly_nxt = DLY_LOAD;
            if (START_DELAY == 0) state_nxt = RUN;
            else                  state_nxt = DELAY;
        end else if (en) begin
            unique case (state)
                DELAY: begin
                    if (dly_cnt == '0) state_nxt = RUN;
                    else               dly_nxt   = dly_cnt - DLY_W'(1);
                end
                RUN: begin
                    ii_nxt = (ii_cnt == II_MAX) ? '0 : ii_cnt + II_W'(1);
                    if (valid) begin
                        if (last) begin
                            state_nxt = DONE;
                        end else begin
                            // Odometer ripples from the innermost level; the final
                            // iteration is diverted to DONE, so the outer carry never escapes.
                            for (int unsigned k = 0; k < 4; k++) begin
                                if (carry) begin
                                    if (at_end[3-k]) begin
                                        vars_nxt[3-k] = '0;
                                    end else begin
                                        vars_nxt[3-k] = ctrl_vars[3-k] + W'(1);
                                        carry         = 1'b0;
                                    end
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dly_cnt <= '0;
            ii_cnt  <= '0;
            for (int unsigned i = 0; i < 4; i++) ctrl_vars[i] <= '0;
        end else begin
            state     <= state_nxt;
            dly_cnt   <= dly_nxt;
            ii_cnt    <= ii_nxt;
            ctrl_vars <= vars_nxt;
        end
    end

endmodule
